// File: rtl/video_pkg.sv
// ============================================================================
//  Module   : video_pkg
//  Brief    : Shared types and helpers for the pixel stream source.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package video_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_VS = 2'd0,
        ST_ARMED   = 2'd1,
        ST_ACTIVE  = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    typedef struct packed {
        logic sop;
        logic eop;
        logic valid;
    } beat_t;

    // A counter needs at least one bit even when its range is a single value.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/frame_counter.sv
// ============================================================================
//  Module   : frame_counter
//  Brief    : Column/row pixel counters with last-pixel and line-complete flags.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module frame_counter
    import video_pkg::*;
#(
    parameter int H_ACTIVE = 1920,
    parameter int V_ACTIVE = 1080
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_clear,
    input  logic i_inc,
    output logic o_last,
    output logic o_line_done
);

    localparam int c_CW = cnt_width(H_ACTIVE);
    localparam int c_RW = cnt_width(V_ACTIVE);
    localparam logic [c_CW-1:0] c_COL_LAST = c_CW'(H_ACTIVE - 1);
    localparam logic [c_RW-1:0] c_ROW_LAST = c_RW'(V_ACTIVE - 1);

    logic [c_CW-1:0] r_col;
    logic [c_RW-1:0] r_row;
    logic [c_CW-1:0] w_col_cur;
    logic [c_RW-1:0] w_row_cur;
    logic            w_col_wrap;
    logic            w_row_wrap;

    // A clear in the same cycle as an increment counts that pixel as the first of the frame.
    always_comb begin
        w_col_cur   = i_clear ? '0 : r_col;
        w_row_cur   = i_clear ? '0 : r_row;
        w_col_wrap  = (w_col_cur == c_COL_LAST);
        w_row_wrap  = (w_row_cur == c_ROW_LAST);
        o_last      = w_col_wrap && w_row_wrap;
        o_line_done = (w_col_cur == '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_inc) begin
            if (w_col_wrap) begin
                r_col <= '0;
                r_row <= w_row_wrap ? '0 : w_row_cur + 1'b1;
            end else begin
                r_col <= w_col_cur + 1'b1;
                r_row <= w_row_cur;
            end
        end else if (i_clear) begin
            r_col <= '0;
            r_row <= '0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/sync_to_stream.sv
// ============================================================================
//  Module   : sync_to_stream
//  Brief    : Converts vsync/de/RGB timing into sop/eop-framed stream beats.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module sync_to_stream
    import video_pkg::*;
#(
    parameter int W        = 10,
    parameter int H_ACTIVE = 1920,
    parameter int V_ACTIVE = 1080,
    parameter bit VS_POL   = 1'b1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         vsync_i,
    input  logic         de_i,
    input  logic [W-1:0] data_r_i,
    input  logic [W-1:0] data_g_i,
    input  logic [W-1:0] data_b_i,
    output logic [W-1:0] data_r_o,
    output logic [W-1:0] data_g_o,
    output logic [W-1:0] data_b_o,
    output logic         sop_o,
    output logic         eop_o,
    output logic         valid_o,
    output logic         frame_err_o
);

    state_t       r_state;
    state_t       w_eff_state;
    beat_t        r_beat;
    logic         r_vs_d;
    logic         r_err_done;
    logic         r_frame_err;
    logic [W-1:0] r_data_r;
    logic [W-1:0] r_data_g;
    logic [W-1:0] r_data_b;
    logic         w_vs_act;
    logic         w_vs_edge;
    logic         w_beat;
    logic         w_last;
    logic         w_line_done;

    assign w_vs_act  = (vsync_i == VS_POL);
    assign w_vs_edge = w_vs_act && !r_vs_d;

    // A frame boundary is processed before any pixel in the same cycle.
    always_comb begin
        w_eff_state = r_state;
        if (w_vs_edge) begin
            w_eff_state = ST_ARMED;
        end
    end

    assign w_beat = de_i && ((w_eff_state == ST_ARMED) || (w_eff_state == ST_ACTIVE));

    frame_counter #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE)
    ) u_frame_counter (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_clear     (w_vs_edge),
        .i_inc       (w_beat),
        .o_last      (w_last),
        .o_line_done (w_line_done)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_WAIT_VS;
            r_beat      <= '0;
            r_vs_d      <= 1'b0;
            r_err_done  <= 1'b0;
            r_frame_err <= 1'b0;
            r_data_r    <= '0;
            r_data_g    <= '0;
            r_data_b    <= '0;
        end else begin
            r_vs_d      <= w_vs_act;
            r_beat      <= '0;
            r_frame_err <= 1'b0;

            if (w_beat) begin
                r_data_r     <= data_r_i;
                r_data_g     <= data_g_i;
                r_data_b     <= data_b_i;
                r_beat.valid <= 1'b1;
                r_beat.sop   <= (w_eff_state == ST_ARMED);
                r_beat.eop   <= w_last;
            end

            unique case (w_eff_state)
                ST_WAIT_VS: r_state <= ST_WAIT_VS;
                ST_ARMED: begin
                    if (de_i) begin
                        r_state <= w_last ? ST_DONE : ST_ACTIVE;
                    end else begin
                        r_state <= ST_ARMED;
                    end
                end
                ST_ACTIVE: begin
                    if (de_i) begin
                        if (w_last) begin
                            r_state <= ST_DONE;
                        end
                    end else if (!w_line_done) begin
                        r_frame_err <= 1'b1;
                        r_state     <= ST_WAIT_VS;
                    end
                end
                ST_DONE: begin
                    if (de_i && !r_err_done) begin
                        r_frame_err <= 1'b1;
                        r_err_done  <= 1'b1;
                    end
                end
                default: r_state <= ST_WAIT_VS;
            endcase

            if (w_vs_edge) begin
                r_err_done <= 1'b0;
                if (r_state == ST_ACTIVE) begin
                    r_frame_err <= 1'b1;
                end
            end
        end
    end

    assign data_r_o    = r_data_r;
    assign data_g_o    = r_data_g;
    assign data_b_o    = r_data_b;
    assign sop_o       = r_beat.sop;
    assign eop_o       = r_beat.eop;
    assign valid_o     = r_beat.valid;
    assign frame_err_o = r_frame_err;

endmodule

`default_nettype wire

// File: tb/tb_sync_to_stream.sv
// ============================================================================
//  Module   : tb_sync_to_stream
//  Brief    : Self-checking bench for sync_to_stream against a pixel-count model.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sync_to_stream;

    localparam int W = 10;
    localparam int H = 4;
    localparam int V = 3;
    localparam int N = H * V;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         vsync_i = 1'b0;
    logic         de_i = 1'b0;
    logic [W-1:0] data_r_i = '0;
    logic [W-1:0] data_g_i = '0;
    logic [W-1:0] data_b_i = '0;
    logic [W-1:0] data_r_o;
    logic [W-1:0] data_g_o;
    logic [W-1:0] data_b_o;
    logic         sop_o;
    logic         eop_o;
    logic         valid_o;
    logic         frame_err_o;

    int n_total = 0;
    int n_bad   = 0;

    // Model: frame progress tracked as a plain pixel index within the frame.
    bit m_locked, m_finished, m_err_reported, m_prev_vs;
    int m_pix;
    logic         e_valid, e_sop, e_eop, e_err;
    logic [W-1:0] e_r, e_g, e_b;

    sync_to_stream #(
        .W        (W),
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .VS_POL   (1'b1)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .vsync_i     (vsync_i),
        .de_i        (de_i),
        .data_r_i    (data_r_i),
        .data_g_i    (data_g_i),
        .data_b_i    (data_b_i),
        .data_r_o    (data_r_o),
        .data_g_o    (data_g_o),
        .data_b_o    (data_b_o),
        .sop_o       (sop_o),
        .eop_o       (eop_o),
        .valid_o     (valid_o),
        .frame_err_o (frame_err_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_locked = 0; m_finished = 0; m_err_reported = 0; m_prev_vs = 0; m_pix = 0;
        e_valid = 0; e_sop = 0; e_eop = 0; e_err = 0;
        e_r = '0; e_g = '0; e_b = '0;
    endtask

    task automatic model_step(input bit vs, input bit de);
        bit vs_edge;
        vs_edge = vs && !m_prev_vs;
        m_prev_vs = vs;
        e_valid = 0; e_sop = 0; e_eop = 0; e_err = 0;
        if (vs_edge) begin
            if (m_locked && m_pix > 0 && !m_finished) e_err = 1;
            m_locked = 1; m_finished = 0; m_err_reported = 0; m_pix = 0;
        end
        if (m_locked) begin
            if (de) begin
                if (!m_finished) begin
                    e_valid = 1;
                    e_sop = (m_pix == 0);
                    e_eop = (m_pix == N - 1);
                    e_r = data_r_i; e_g = data_g_i; e_b = data_b_i;
                    m_pix++;
                    if (m_pix == N) m_finished = 1;
                end else if (!m_err_reported) begin
                    e_err = 1;
                    m_err_reported = 1;
                end
            end else if (!m_finished && m_pix > 0 && (m_pix % H) != 0) begin
                e_err = 1;
                m_locked = 0;
            end
        end
    endtask

    task automatic check_outputs();
        check_eq("valid", valid_o, e_valid);
        check_eq("sop", sop_o, e_sop);
        check_eq("eop", eop_o, e_eop);
        check_eq("frame_err", frame_err_o, e_err);
        check_eq("data_r", data_r_o, e_r);
        check_eq("data_g", data_g_o, e_g);
        check_eq("data_b", data_b_o, e_b);
    endtask

    task automatic step(input bit vs, input bit de);
        vsync_i  = vs;
        de_i     = de;
        data_r_i = W'($urandom);
        data_g_i = W'($urandom);
        data_b_i = W'($urandom);
        model_step(vs, de);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic vs_pulse();
        step(1, 0);
        step(1, 0);
        step(0, 0);
    endtask

    task automatic line(input int npix, input int gap);
        repeat (npix) step(0, 1);
        repeat (gap) step(0, 0);
    endtask

    task automatic frame(input int gap);
        vs_pulse();
        repeat (V) line(H, gap);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        reset_n = 1'b1;

        // Good frame with inter-line gaps
        frame(2);
        line(0, 3);
        // Back-to-back frames, no line gaps
        frame(0);
        frame(0);
        // Short line 1, rest dropped, then good frame
        vs_pulse();
        line(4, 1);
        line(3, 2);
        line(4, 1);
        frame(1);
        // Early vsync after 6 pixels, then a full frame
        vs_pulse();
        line(4, 1);
        line(2, 0);
        vs_pulse();
        repeat (V) line(H, 1);
        // vsync edge coincident with the first pixel after DONE
        step(1, 1);
        line(3, 1);
        line(4, 0);
        line(4, 2);
        // Extra pixels after the last one, then good frame
        frame(1);
        line(2, 1);
        frame(1);
        // Asynchronous reset mid-frame
        vs_pulse();
        line(4, 1);
        line(1, 0);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        #4 reset_n = 1'b1;
        line(4, 2);
        frame(1);

        // Random timing: occasional vsync, mostly-high de
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 24) == 0, $urandom_range(0, 4) != 0);
        end
        frame(1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
